// File: rtl/switch_conditioner.sv
// Front end for the vacuum-cleaner FSM: synchronises, debounces and edge-detects each
// switch, then resolves the stable levels into one priority-encoded command.
module switch_conditioner #(
    parameter int N_SW            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [1:0]      cmd,
    output logic            cmd_valid,
    output logic            cmd_change
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        CMD_POWER_OFF = 2'b00,
        CMD_ON        = 2'b01,
        CMD_CLEANING  = 2'b10,
        CMD_EVADING   = 2'b11
    } cmd_e;

    if (N_SW != 4) begin : g_bad_n_sw
        $error("switch_conditioner: command encoding requires N_SW == 4");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("switch_conditioner: SYNC_STAGES must be in 2..4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("switch_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end

    logic [N_SW-1:0]  sync_pipe [SYNC_STAGES];
    logic [N_SW-1:0]  sync;
    logic [CNT_W-1:0] cnt       [N_SW];
    cmd_e             cmd_next;
    logic [2:0]       cmd_prev;

    assign sync = sync_pipe[SYNC_STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= '0;
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
            sw_level <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
        end else begin
            sync_pipe[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];

            // A change is accepted only after DEBOUNCE_CYCLES consecutive differing
            // cycles; any agreeing cycle restarts the count, so it never wraps.
            for (int i = 0; i < N_SW; i++) begin
                sw_rise[i] <= 1'b0;
                sw_fall[i] <= 1'b0;
                if (sync[i] == sw_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]      <= '0;
                    sw_level[i] <= sync[i];
                    sw_rise[i]  <= sync[i];
                    sw_fall[i]  <= ~sync[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the default assignment first keeps this purely combinational (no latch).
    always_comb begin
        cmd_next = CMD_POWER_OFF;
        if (sw_level[0])      cmd_next = CMD_POWER_OFF;
        else if (sw_level[3]) cmd_next = CMD_EVADING;
        else if (sw_level[2]) cmd_next = CMD_CLEANING;
        else if (sw_level[1]) cmd_next = CMD_ON;
    end

    // cmd_change compares the registered command with its value one cycle earlier,
    // so the pulse lands the cycle after the command itself moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd        <= 2'b00;
            cmd_valid  <= 1'b0;
            cmd_prev   <= 3'b000;
            cmd_change <= 1'b0;
        end else begin
            cmd        <= cmd_next;
            cmd_valid  <= |sw_level;
            cmd_prev   <= {cmd_valid, cmd};
            cmd_change <= ({cmd_valid, cmd} != cmd_prev);
        end
    end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input front end for the vacuum-cleaner Moore FSM; sits directly upstream of it, between the raw ui_in switch pins and the FSM command inputs.
- Per switch: synchronises the asynchronous level, debounces it, and produces a clean level plus one-cycle rise/fall pulses.
- Also resolves simultaneous switches into a single priority-encoded command, so the FSM never sees conflicting requests.

Parameters:
- N_SW, 4, number of switch channels (bit 0 power_off, 1 on, 2 cleaning, 3 evading)
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (legal range 2..4)
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised input must differ from the stable value before it is accepted (legal range >= 2)
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived; not overridden)

Ports:
- clk  input  1  system clock; the only clock
- rst  input  1  synchronous reset, active-high
- sw_raw  input  N_SW  raw asynchronous switch pins (ui_in[3:0])
- sw_level  output  N_SW  debounced stable level per channel
- sw_rise  output  N_SW  one-cycle pulse on each accepted 0->1 change
- sw_fall  output  N_SW  one-cycle pulse on each accepted 1->0 change
- cmd  output  2  priority-encoded command: 00 power_off, 01 on, 10 cleaning, 11 evading
- cmd_valid  output  1  at least one sw_level bit is 1
- cmd_change  output  1  one-cycle pulse when {cmd_valid,cmd} changes

Behaviour:
- Reset (rst=1 at a clk edge): all synchroniser flops, debounce counters, sw_level, sw_rise, sw_fall, cmd, cmd_valid and cmd_change go to 0 on that edge. Reset has priority over every other action, including a debounce count in progress; the count restarts from 0 after release.
- Synchroniser: SYNC_STAGES-deep shift per channel. sync[i] is the last stage; no logic reads earlier stages.
- Debounce, per channel, evaluated every cycle:
  - If sync[i] == sw_level[i]: counter clears to 0.
  - Else, if counter == DEBOUNCE_CYCLES-1: sw_level[i] <= sync[i] and counter clears to 0.
  - Else: counter increments.
- Glitch rule: any single cycle where sync[i] equals sw_level[i] restarts the count from 0.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Latency: a clean step on sw_raw[i] appears on sw_level[i] exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges after the first edge that samples the new value.
- Pulses: sw_rise[i] / sw_fall[i] are registered and high for exactly one cycle. That cycle is the first cycle sw_level[i] shows the new value. Rise and fall are never both high on one channel.
- Channel independence: channels run independently; several channels may update in the same cycle.
- Priority encoder (registered, one cycle after sw_level): highest priority wins, in the order power_off(0) > evading(3) > cleaning(2) > on(1).
  - cmd_valid = |sw_level.
  - With no bit set: cmd = 00 and cmd_valid = 0.
- cmd_change: high for one cycle in the cycle after the registered {cmd_valid,cmd} differs from its previous value. It is not asserted on the first cycle after reset.
- Widths: fixed at N_SW=4 for cmd encoding. Other N_SW values are out of scope, and elaboration errors via assertion.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: hold rst=1 for 3 cycles with sw_raw=4'hF -> all outputs 0 during reset. After release, sw_level=4'hF exactly 6 cycles later with sw_rise=4'hF for that one cycle. cmd=00 and cmd_valid=1 one cycle after that; cmd_change pulses the following cycle.
- Bounce: sw_raw[1] toggles 1,0,1,0 each cycle, then holds 1 -> sw_level[1] rises only 6 cycles after the final stable 1. Exactly one sw_rise[1] pulse; no sw_fall pulses.
- Priority: stable sw_level=4'b0110 -> cmd=10 (cleaning). Set bit 3 -> cmd=11 with one cmd_change pulse. Set bit 0 -> cmd=00. Clear all -> cmd_valid=0, cmd=00, one cmd_change pulse.
- Reset mid-count: sw_raw[2] goes high, rst pulses for 1 cycle 3 cycles later -> sw_level[2] rises 6 cycles after rst release, not earlier.
- Simultaneous edges: sw_raw goes 4'b0001 -> 4'b1000 on one edge -> in the same cycle sw_fall[0]=1 and sw_rise[3]=1, sw_level=4'b1000. cmd goes 00 -> 11 with a single cmd_change pulse.
- Exact threshold: sw_raw[3] held high for 3 cycles then low -> sw_level[3] never rises; held for 4 cycles -> it rises.
